// File: rtl/imm_encoder_if.sv
// Request/response bundle for imm_encoder. The master modport issues requests and consumes
// packed words; the slave modport is the encoder side.
interface imm_encoder_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_fmt;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [63:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err;
  logic [7:0]        err_cnt;

  modport master (
    output in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err, err_cnt
  );

  modport slave (
    input  in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err, err_cnt
  );
endinterface

// File: rtl/imm_encoder.sv
// Packs load/store/branch fields into RV64 instruction words behind a one-entry valid/ready
// output stage. Define IMM_ENC_RANGE_CHECK_EN to reject immediates outside -2048..2047.
module imm_encoder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDR_STEP = 4
) (
  input logic          clk,
  input logic          reset,
  imm_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    FmtLoad    = 2'b00,
    FmtStore   = 2'b01,
    FmtIllegal = 2'b10,
    FmtBranch  = 2'b11
  } fmt_e;

  typedef enum logic {StEmpty, StFull} state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [ADDR_W-1:0] AddrBase = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] AddrStep = ADDR_W'(ADDR_STEP);

  state_e            state_q;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic [7:0]        err_cnt_q;

  fmt_e        fmt;
  logic [11:0] imm12;
  logic [31:0] packed_instr;
  logic        fmt_ok;
  logic        imm_ok;
  logic        legal;
  logic        accept;
  logic        out_hs;

  assign fmt    = fmt_e'(bus.in_fmt);
  assign imm12  = bus.in_imm[11:0];
  assign fmt_ok = (fmt != FmtIllegal);

`ifdef IMM_ENC_RANGE_CHECK_EN
  // Bits 63:11 all equal means the value survives truncation to a signed 12-bit field.
  assign imm_ok = (&bus.in_imm[63:11]) | ~(|bus.in_imm[63:11]);
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^bus.in_imm[63:12];
  assign imm_ok        = 1'b1;
`endif

  assign legal  = fmt_ok & imm_ok;
  assign accept = bus.in_valid & bus.in_ready;
  assign out_hs = (state_q == StFull) & bus.out_ready;

  always_comb begin
    packed_instr = '0;
    case (fmt)
      FmtLoad: begin
        packed_instr = {imm12, bus.in_rs1, bus.in_funct3, bus.in_rd, OpLoad};
      end
      FmtStore: begin
        packed_instr = {imm12[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm12[4:0], OpStore};
      end
      FmtBranch: begin
        // Halfword offset: bit 10 lands in instr[7], bits 3:0 in instr[11:8].
        packed_instr = {imm12[11], imm12[9:4], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        imm12[3:0], imm12[10], OpBranch};
      end
      default: packed_instr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StEmpty;
      instr_q   <= '0;
      addr_q    <= AddrBase;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (out_hs) begin
        addr_q <= addr_q + AddrStep;
      end

      if (accept && legal) begin
        state_q <= StFull;
        instr_q <= packed_instr;
      end else if (out_hs) begin
        state_q <= StEmpty;
      end

      if (accept && !legal) begin
        err_q <= 1'b1;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
      end
    end
  end

  assign bus.in_ready  = (state_q == StEmpty) | bus.out_ready;
  assign bus.out_valid = (state_q == StFull);
  assign bus.out_instr = instr_q;
  assign bus.out_addr  = addr_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vector table, hand-written handshake corner cases and a
// randomized run against a queue-based reference model.
module tb_imm_encoder;

  localparam int unsigned AW   = 8;
  localparam int unsigned BASE = 0;
  localparam int unsigned STEP = 4;
`ifdef IMM_ENC_RANGE_CHECK_EN
  localparam bit RangeEn = 1'b1;
`else
  localparam bit RangeEn = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imm_encoder_if #(.ADDR_W(AW)) bus ();

  imm_encoder #(
    .ADDR_W   (AW),
    .BASE_ADDR(BASE),
    .ADDR_STEP(STEP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [63:0] imm;
    logic [31:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] fmt, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [63:0] imm);
    bus.in_valid  = v;
    bus.in_fmt    = fmt;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_imm    = imm;
  endtask

  task automatic drive_vec(input vec_t v);
    drive(1'b1, v.fmt, v.rd, v.rs1, v.rs2, v.f3, v.imm);
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0);
  endtask

  // Reference encoding built from field positions with plain shifts and masks.
  function automatic logic [31:0] ref_pack(input logic [1:0] fmt, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [2:0] f3, input logic [63:0] imm);
    logic [31:0] i;
    logic [31:0] common;
    i      = 32'(imm & 64'hFFF);
    common = (32'(rs1) << 15) | (32'(f3) << 12);
    case (fmt)
      2'b00:   return (i << 20) | common | (32'(rd) << 7) | 32'h03;
      2'b01:   return ((i >> 5) << 25) | (32'(rs2) << 20) | common | ((i & 32'h1F) << 7)
                      | 32'h23;
      2'b11:   return (((i >> 11) & 32'h1) << 31) | (((i >> 4) & 32'h3F) << 25)
                      | (32'(rs2) << 20) | common | ((i & 32'hF) << 8)
                      | (((i >> 10) & 32'h1) << 7) | 32'h63;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [1:0] fmt, input logic [63:0] imm);
    longint s;
    bit     in_range;
    s        = longint'(imm);
    in_range = (s >= -64'sd2048) && (s <= 64'sd2047);
    return (fmt != 2'b10) && (!RangeEn || in_range);
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [6];
    vec_t        va;
    vec_t        vb;
    int          exp_addr;
    int          n_ill;
    int          n_out;
    logic [31:0] exp_q[$];
    logic [63:0] imm;
    logic [1:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    bit          model_ready;
    int          bnd [4];

    tbl[0] = '{2'b00, 5'd5,  5'd2,  5'd0,  3'd3, 64'd8,                  32'h00813283};
    tbl[1] = '{2'b01, 5'd0,  5'd2,  5'd6,  3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFE613E23};
    tbl[2] = '{2'b11, 5'd0,  5'd1,  5'd2,  3'd0, 64'd4,                  32'h00208463};
    tbl[3] = '{2'b00, 5'd1,  5'd0,  5'd0,  3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFF00083};
    tbl[4] = '{2'b01, 5'd0,  5'd31, 5'd31, 3'd7, 64'd2047,               32'h7FFFFFA3};
    tbl[5] = '{2'b11, 5'd0,  5'd0,  5'd0,  3'd0, 64'hFFFF_FFFF_FFFF_F800, 32'h80000063};
    bnd    = '{-2049, -2048, 2047, 2048};
    va     = tbl[0];
    vb     = tbl[1];

    idle();
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_instr", bus.out_instr, 32'h0);
    check("rst_out_addr",  bus.out_addr,  BASE);
    check("rst_err",       bus.err,       1'b0);
    check("rst_err_cnt",   bus.err_cnt,   8'd0);
    check("rst_in_ready",  bus.in_ready,  1'b1);

    // Table vectors back to back with out_ready high: one word per cycle.
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      if (k < 6) drive_vec(tbl[k]);
      else idle();
      #1;
      check("tbl_in_ready",  bus.in_ready,  1'b1);
      check("tbl_out_valid", bus.out_valid, k > 0);
      if (k > 0) begin
        check("tbl_out_instr", bus.out_instr, tbl[k-1].exp);
        check("tbl_out_addr",  bus.out_addr,  ((k - 1) * STEP + BASE) % 256);
      end
    end
    @(negedge clk);
    #1;
    check("tbl_drained", bus.out_valid, 1'b0);
    exp_addr = (6 * STEP + BASE) % 256;
    n_ill    = 0;

    // Out-of-range load immediate.
    @(negedge clk);
    drive(1'b1, 2'b00, 5'd5, 5'd2, 5'd0, 3'd3, 64'd2048);
    @(negedge clk);
    idle();
    #1;
`ifdef IMM_ENC_RANGE_CHECK_EN
    check("oor_out_valid", bus.out_valid, 1'b0);
    check("oor_err",       bus.err,       1'b1);
    check("oor_err_cnt",   bus.err_cnt,   8'd1);
    check("oor_out_addr",  bus.out_addr,  exp_addr);
    n_ill = 1;
`else
    check("oor_out_valid", bus.out_valid, 1'b1);
    check("oor_out_instr", bus.out_instr, 32'h80013283);
    check("oor_out_addr",  bus.out_addr,  exp_addr);
    check("oor_err",       bus.err,       1'b0);
    exp_addr = (exp_addr + STEP) % 256;
`endif
    @(negedge clk);
    #1;
    check("oor_drained", bus.out_valid, 1'b0);

    // Backpressure: word A held for three cycles while B waits.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_vec(va);
    @(negedge clk);
    drive_vec(vb);
    for (int j = 0; j < 3; j++) begin
      #1;
      check("bp_in_ready",  bus.in_ready,  1'b0);
      check("bp_out_valid", bus.out_valid, 1'b1);
      check("bp_out_instr", bus.out_instr, va.exp);
      check("bp_out_addr",  bus.out_addr,  exp_addr);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    idle();
    #1;
    exp_addr = (exp_addr + STEP) % 256;
    check("bp_next_valid", bus.out_valid, 1'b1);
    check("bp_next_instr", bus.out_instr, vb.exp);
    check("bp_next_addr",  bus.out_addr,  exp_addr);
    @(negedge clk);
    #1;
    exp_addr = (exp_addr + STEP) % 256;
    check("bp_drained", bus.out_valid, 1'b0);

    // Illegal format while empty.
    drive(1'b1, 2'b10, 5'd1, 5'd1, 5'd1, 3'd1, 64'd0);
    @(negedge clk);
    idle();
    #1;
    n_ill++;
    check("ill_err",       bus.err,       1'b1);
    check("ill_err_cnt",   bus.err_cnt,   n_ill);
    check("ill_out_valid", bus.out_valid, 1'b0);
    check("ill_out_addr",  bus.out_addr,  exp_addr);

    // Illegal accept while a word drains: word leaves, error still counted.
    drive_vec(va);
    @(negedge clk);
    drive(1'b1, 2'b10, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0);
    #1;
    check("drill_valid", bus.out_valid, 1'b1);
    @(negedge clk);
    idle();
    #1;
    n_ill++;
    exp_addr = (exp_addr + STEP) % 256;
    check("drill_out_valid", bus.out_valid, 1'b0);
    check("drill_err_cnt",   bus.err_cnt,   n_ill);
    check("drill_out_addr",  bus.out_addr,  exp_addr);

    // Reset while full and stalled.
    bus.out_ready = 1'b0;
    drive_vec(va);
    @(negedge clk);
    idle();
    reset = 1'b1;
    #1;
    check("rstf_pre_valid", bus.out_valid, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstf_out_valid", bus.out_valid, 1'b0);
    check("rstf_err",       bus.err,       1'b0);
    check("rstf_err_cnt",   bus.err_cnt,   8'd0);
    check("rstf_out_addr",  bus.out_addr,  BASE);

    // Randomized run against the queue model.
    n_ill = 0;
    n_out = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      fmt = 2'($urandom_range(0, 3));
      rd  = 5'($urandom);
      rs1 = 5'($urandom);
      rs2 = 5'($urandom);
      f3  = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       imm = {$urandom, $urandom};
        1:       imm = 64'(longint'(bnd[$urandom_range(0, 3)]));
        default: imm = 64'(longint'($urandom_range(0, 4095)) - 64'sd2048);
      endcase
      drive(($urandom_range(0, 3) != 0), fmt, rd, rs1, rs2, f3, imm);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      model_ready = (exp_q.size() == 0) || bus.out_ready;
      check("rnd_out_valid", bus.out_valid, exp_q.size() != 0);
      check("rnd_in_ready",  bus.in_ready,  model_ready);
      check("rnd_err",       bus.err,       n_ill != 0);
      check("rnd_err_cnt",   bus.err_cnt,   (n_ill > 255) ? 255 : n_ill);
      if (exp_q.size() != 0 && bus.out_ready) begin
        check("rnd_out_instr", bus.out_instr, exp_q[0]);
        check("rnd_out_addr",  bus.out_addr,  (BASE + n_out * STEP) % 256);
        void'(exp_q.pop_front());
        n_out++;
      end
      if (bus.in_valid && model_ready) begin
        if (ref_legal(fmt, imm)) exp_q.push_back(ref_pack(fmt, rd, rs1, rs2, f3, imm));
        else n_ill++;
      end
    end

    // Error counter saturation.
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b10, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0);
    repeat (254) @(negedge clk);
    #1;
    check("sat_err_cnt_254", bus.err_cnt, 8'd254);
    repeat (6) @(negedge clk);
    idle();
    #1;
    check("sat_err_cnt", bus.err_cnt, 8'd255);
    check("sat_err",     bus.err,     1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
